// File: rtl/wb_fifo_8bit_pkg.sv
// Shared definitions for the write-back FIFO: data width, default geometry,
// reset fill value and the per-cycle pointer operation encoding.
package wb_fifo_8bit_pkg;

  localparam int          WB_DATA_W     = 8;
  localparam int          WB_DEPTH      = 4;
  localparam int          WB_AW         = 2;
  localparam logic [7:0]  WB_RESET_DATA = 8'h00;

  // What the buffer does on a given edge; drives the count update.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/wb_fifo_8bit_mem.sv
// Storage array for the write-back FIFO: DEPTH x DW entries, synchronous
// write, asynchronous read, asynchronous clear to the reset fill value.
module wb_fifo_mem
  import wb_fifo_8bit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DATA_W
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Entry storage: cleared on reset so stale data never leaks out after a flush.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DW'(WB_RESET_DATA);
      end
    end else if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/wb_fifo_8bit.sv
// Write-back buffer in front of the 8-bit data register. Accepts results
// under valid/ready and drains them in order as a data + write-enable pair.
// Optional feature macro: WB_FIFO_BYPASS_EN -- when defined, a result
// arriving at an empty, unstalled buffer goes straight to the outputs in the
// same cycle without being stored.
module wb_fifo_8bit
  import wb_fifo_8bit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [WB_DATA_W-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_stall,
  output logic [WB_DATA_W-1:0] o_data,
  output logic                 o_we,
  output logic [AW:0]          o_count,
  output logic                 o_empty,
  output logic                 o_full
);

  logic [AW-1:0]        wrPtr_q, wrPtr_d;
  logic [AW-1:0]        rdPtr_q, rdPtr_d;
  logic [AW:0]          count_q, count_d;
  logic [WB_DATA_W-1:0] headData;
  logic                 empty;
  logic                 full;
  logic                 bypass;
  logic                 push;
  logic                 pop;
  fifo_op_e             op;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

`ifdef WB_FIFO_BYPASS_EN
  assign bypass = empty & ~i_stall & i_valid;
`else
  assign bypass = 1'b0;
`endif

  // A full buffer refuses pushes even if it drains this cycle; a bypassed
  // datum never enters storage.
  assign push = i_valid & ~full & ~bypass;
  assign pop  = ~empty & ~i_stall;
  assign op   = fifo_op_e'({push, pop});

  wb_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (WB_DATA_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (push),
    .i_waddr (wrPtr_q),
    .i_wdata (i_data),
    .i_raddr (rdPtr_q),
    .o_rdata (headData)
  );

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case (op)
      OP_PUSH: count_d = count_q + (AW+1)'(1);
      OP_POP:  count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every held entry.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Output drive: head entry (or the bypassed input) plus the drain strobe.
  always_comb begin
    o_we   = pop | bypass;
    o_data = WB_RESET_DATA;
    if (bypass) begin
      o_data = i_data;
    end else if (!empty) begin
      o_data = headData;
    end
  end

  assign o_ready = ~full;
  assign o_count = count_q;
  assign o_empty = empty;
  assign o_full  = full;

endmodule
